ifetch_pc_gen: RTL
==================

// Module: ifetch_pc_gen
// PURPOSE
//  Program-counter source directly upstream of ifetch. Drives ifetch.addr and
//  ifetch.prev_stalled, and consumes ifetch.stall_prev as back-pressure.
//  Advances sequentially by one ILEN word per accepted fetch and takes
//  redirects (branch/trap targets) from execute. Emits a flush pulse so that
//  downstream stages can drop any in-flight wrong-path instruction.
// PARAMETERS
//  RESET_VECTOR  'h0        first fetch address after reset (`ALEN bits)
//  STEP          `ILEN/8    byte increment per accepted fetch (4)
// PORTS
//  clk            in   1       clock
//  rst            in   1       async reset, active-high
//  redirect       in   1       load redirect_addr as next fetch address
//  redirect_addr  in   `ALEN   redirect target; bit 0 passed unchecked
//  halt           in   1       debug halt; suppress new fetches while high
//  next_stalled   in   1       ifetch.stall_prev; 1 = cannot accept addr
//  addr           out  `ALEN   fetch address (to ifetch.addr)
//  stall_next     out  1       1 = addr not valid (to ifetch.prev_stalled)
//  flush          out  1       1-cycle pulse: discard in-flight fetches
// BEHAVIOUR
//  - Reset values (async): addr=RESET_VECTOR, stall_next=1, flush=0, state=BOOT.
//  - All outputs registered. next_stalled is combinational in ifetch and may
//    glitch mid-cycle, so sample it only at posedge clk.
//  - Transfer = posedge where stall_next==0 && next_stalled==0.
//  - FSM states:
//    BOOT:   stall_next=1. Go to HALTED if halt, else RUN, on the next edge.
//    RUN:    stall_next=0. On transfer: addr <= addr+STEP, mod 2^ALEN, so
//            'hFFFF_FFFC -> 'h0. If not transferred, hold addr; no skip, no
//            repeat. halt=1 -> HALTED and stall_next=1 on the next edge.
//    HALTED: stall_next=1, addr held. halt=0 -> RUN on the next edge.
//  - Redirect (sampled at posedge, any state except BOOT):
//    addr <= redirect_addr, and flush=1 for exactly the following cycle.
//    Redirect has priority over increment. If a transfer happens on the same
//    edge, the old addr is still handed to ifetch, and flush marks it stale.
//    State is unchanged by a redirect: a redirect while HALTED updates addr
//    and stays HALTED.
//    Redirect in BOOT is ignored; execute cannot issue one then.
//  - Back-to-back redirects: the last one wins, and flush stays high on each
//    following cycle.
//  - redirect and halt asserted together: both take effect. New addr, HALTED,
//    flush pulsed.
//  - Misaligned redirect_addr (bit0=1) is forwarded unchanged. ifetch raises
//    ifetch_exception for it. Sequential increment preserves bit 0.
//  - Reset mid-operation: immediate return to reset values. No flush pulse.
//  - Throughput: one address per cycle when next_stalled stays 0.
// TESTING
//  1. Release reset, next_stalled=0 -> stall_next 1 for 1 cycle, then addr
//     0x0,0x4,0x8,0xC on consecutive cycles.
//  2. next_stalled=1 for 5 cycles at addr 0x8 -> addr holds 0x8 and
//     stall_next=0 throughout; after release, next addr is 0xC.
//  3. Pulse redirect with redirect_addr=0xAA0536 during a transfer of 0x10
//     -> 0x10 accepted; next addr 0xAA0536, flush=1 one cycle, then 0xAA053A.
//  4. Raise halt at 0x20 -> stall_next=1 and addr holds 0x20. Redirect to 0xCD
//     while halted -> addr 0xCD, still halted. Drop halt -> fetch 0xCD, 0xD1.
//  5. Redirect to 0xFFFF_FFF8, next_stalled=0 -> 0xFFFF_FFF8, 0xFFFF_FFFC,
//     0x0.
//  6. Assert rst mid-RUN at addr 0x40 -> addr=RESET_VECTOR and stall_next=1
//     asynchronously; flush=0. Glitch next_stalled between edges -> no effect.

Source files
------------

// File: rtl/ifetch_pc_gen_if.sv
// Fetch-address handshake between the PC source, ifetch and execute.
// master = PC generator side, slave = ifetch/execute side.
interface ifetch_pc_gen_if #(
  parameter int ALEN = 32
);
  logic            redirect;
  logic [ALEN-1:0] redirect_addr;
  logic            halt;
  logic            next_stalled;
  logic [ALEN-1:0] addr;
  logic            stall_next;
  logic            flush;

  modport master (
    input  redirect,
    input  redirect_addr,
    input  halt,
    input  next_stalled,
    output addr,
    output stall_next,
    output flush
  );

  modport slave (
    output redirect,
    output redirect_addr,
    output halt,
    output next_stalled,
    input  addr,
    input  stall_next,
    input  flush
  );
endinterface

// File: rtl/ifetch_pc_gen.sv
// Program-counter source feeding ifetch: sequential step, redirects, halt.
// Ports: clk, rst (async high), pc (master: redirect/halt/next_stalled in;
// addr/stall_next/flush out, all registered).
module ifetch_pc_gen #(
  parameter int              ALEN         = 32,
  parameter logic [ALEN-1:0] RESET_VECTOR = '0,
  parameter int              STEP         = 4
) (
  input logic           clk,
  input logic           rst,
  ifetch_pc_gen_if.master pc
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [ALEN-1:0] STEP_W = ALEN'(STEP);

  state_t          state_q;
  state_t          state_d;
  logic [ALEN-1:0] addr_q;
  logic [ALEN-1:0] addr_d;
  logic            stall_q;
  logic            stall_d;
  logic            flush_q;
  logic            flush_d;

  logic            xfer;
  logic            take_redir;
  logic            step_only;

  // The handshake is judged on the registered stall, so a transfer
  // on the same edge as a halt or redirect still hands out old addr.
  assign xfer       = !stall_q && !pc.next_stalled;
  assign take_redir = pc.redirect && (state_q != BOOT);
  assign step_only  = xfer && !take_redir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Halt alone decides the state; redirects never move it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = pc.halt ? HALTED : RUN;
      RUN:     state_d = pc.halt ? HALTED : RUN;
      HALTED:  state_d = pc.halt ? HALTED : RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    flush_d = 1'b0;
    stall_d = (state_d != RUN);
    unique case (1'b1)
      take_redir: begin
        addr_d  = pc.redirect_addr;
        flush_d = 1'b1;
      end
      step_only: begin
        addr_d = addr_q + STEP_W;
      end
      default: begin
        addr_d = addr_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= RESET_VECTOR;
      stall_q <= 1'b1;
      flush_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign pc.addr       = addr_q;
  assign pc.stall_next = stall_q;
  assign pc.flush      = flush_q;

endmodule
